// File: rtl/imem_uart_loader.sv
// Boot loader: receives a length-prefixed program image over 8N1 UART, writes it word by word
// into instruction memory, and releases the processor from reset once the image is complete.
module imem_uart_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  uart_rx,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_waddr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_reset_n,
    output logic                  load_done,
    output logic                  load_error
);

    localparam int              CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [16:0]     CAPACITY  = 17'(2 ** ADDR_WIDTH);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {L_CNT_LO, L_CNT_HI, L_DATA, L_DONE, L_ERR} ld_state_t;

    rx_state_t       rx_state;
    ld_state_t       l_state;
    logic            rx_meta;
    logic            rx_sync;
    logic [CW-1:0]   bit_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      rx_shift;
    logic [7:0]      rx_byte;
    logic            byte_valid;
    logic            frame_err;
    logic [15:0]     count_q;
    logic [15:0]     word_cnt;
    logic [1:0]      byte_idx;
    logic [31:0]     word_sr;

    // UART receiver. The synchroniser flops reset to the idle-high line level so no
    // false start bit is seen as reset is released.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_state   <= RX_IDLE;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            rx_shift   <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            // NOTE: all state here uses non-blocking assignments so every flop samples
            // pre-edge values; blocking would let rx_sync see rx_meta's new value early.
            rx_meta    <= uart_rx;
            rx_sync    <= rx_meta;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    bit_cnt <= '0;
                    bit_idx <= '0;
                    if (!rx_sync) rx_state <= RX_START;
                end
                RX_START: begin
                    if (bit_cnt == HALF_LAST) begin
                        bit_cnt  <= '0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt  <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        if (bit_idx == 3'd7) rx_state <= RX_STOP;
                        else                 bit_idx  <= bit_idx + 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt  <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_sync) begin
                            rx_byte    <= rx_shift;
                            byte_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // Loader. Only control state is reset; the memory being written is external and
    // keeps whatever was already loaded.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            l_state     <= L_CNT_LO;
            count_q     <= '0;
            word_cnt    <= '0;
            byte_idx    <= '0;
            word_sr     <= '0;
            imem_we     <= 1'b0;
            imem_waddr  <= '0;
            imem_wdata  <= '0;
            cpu_reset_n <= 1'b0;
            load_done   <= 1'b0;
            load_error  <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            // Advance after each write, except after the last so the address never wraps.
            if (imem_we && l_state != L_DONE) imem_waddr <= imem_waddr + 1'b1;
            if (l_state == L_DONE) begin
                load_done   <= 1'b1;
                cpu_reset_n <= 1'b1;
            end
            if (frame_err) begin
                l_state    <= L_ERR;
                load_error <= 1'b1;
            end else if (byte_valid) begin
                case (l_state)
                    L_CNT_LO: begin
                        count_q[7:0] <= rx_byte;
                        l_state      <= L_CNT_HI;
                    end
                    L_CNT_HI: begin
                        count_q[15:8] <= rx_byte;
                        if ({rx_byte, count_q[7:0]} == 16'd0) begin
                            l_state <= L_DONE;
                        end else if ({1'b0, rx_byte, count_q[7:0]} > CAPACITY) begin
                            l_state    <= L_ERR;
                            load_error <= 1'b1;
                        end else begin
                            l_state <= L_DATA;
                        end
                    end
                    L_DATA: begin
                        word_sr  <= {rx_byte, word_sr[31:8]};
                        byte_idx <= byte_idx + 1'b1;
                        if (byte_idx == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_wdata <= {rx_byte, word_sr[31:8]};
                            word_cnt   <= word_cnt + 16'd1;
                            if (word_cnt + 16'd1 == count_q) l_state <= L_DONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for imem_uart_loader: UART byte sender, write logger on the falling edge,
// and hand-computed expectations for each load scenario.
module tb_imem_uart_loader;

    localparam int CPB = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        uart_rx = 1'b1;
    logic        imem_we;
    logic [7:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        cpu_reset_n;
    logic        load_done;
    logic        load_error;
    logic        s_we;
    logic [1:0]  s_waddr;
    logic [31:0] s_wdata;
    logic        s_cpu_reset_n;
    logic        s_done;
    logic        s_error;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          wr_n, we_cyc, cpu_cyc, done_cyc, s_wr_n;
    logic [7:0]  wr_addr [16];
    logic [31:0] wr_data [16];
    logic [1:0]  s_last_addr;
    logic [31:0] s_last_data;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    imem_uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(8)) dut (
        .clk(clk), .reset_n(reset_n), .uart_rx(uart_rx),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .cpu_reset_n(cpu_reset_n), .load_done(load_done), .load_error(load_error)
    );

    imem_uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(2)) dut_small (
        .clk(clk), .reset_n(reset_n), .uart_rx(uart_rx),
        .imem_we(s_we), .imem_waddr(s_waddr), .imem_wdata(s_wdata),
        .cpu_reset_n(s_cpu_reset_n), .load_done(s_done), .load_error(s_error)
    );

    // Write and completion logger, cleared while reset is held.
    always @(negedge clk) begin
        if (!reset_n) begin
            wr_n = 0; we_cyc = -1; cpu_cyc = -1; done_cyc = -1; s_wr_n = 0;
        end else begin
            if (imem_we) begin
                if (wr_n < 16) begin
                    wr_addr[wr_n] = imem_waddr;
                    wr_data[wr_n] = imem_wdata;
                end
                wr_n++;
                we_cyc = cyc;
            end
            if (cpu_reset_n && cpu_cyc < 0) cpu_cyc = cyc;
            if (load_done && done_cyc < 0) done_cyc = cyc;
            if (s_we) begin
                s_wr_n++;
                s_last_addr = s_waddr;
                s_last_data = s_wdata;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        wait_cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            wait_cycles(CPB);
        end
        uart_rx = stop_bit;
        wait_cycles(CPB);
        uart_rx = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic reset_dut();
        reset_n = 1'b0;
        uart_rx = 1'b1;
        wait_cycles(3);
        reset_n = 1'b1;
        wait_cycles(2);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"},    32'(imem_we),     32'd0);
        check({tag, "_addr"},  32'(imem_waddr),  32'd0);
        check({tag, "_data"},  imem_wdata,       32'd0);
        check({tag, "_cpu"},   32'(cpu_reset_n), 32'd0);
        check({tag, "_done"},  32'(load_done),   32'd0);
        check({tag, "_err"},   32'(load_error),  32'd0);
    endtask

    initial begin
        wait_cycles(3);
        check_reset_outputs("rst");
        reset_n = 1'b1;
        wait_cycles(2);

        // Single word image 0x00A00513.
        send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
        send_word(32'h00A00513);
        wait_cycles(10);
        check("w1_count", 32'(wr_n), 32'd1);
        check("w1_addr",  32'(wr_addr[0]), 32'd0);
        check("w1_data",  wr_data[0], 32'h00A00513);
        check("w1_cpu",   32'(cpu_reset_n), 32'd1);
        check("w1_done",  32'(load_done), 32'd1);
        check("w1_err",   32'(load_error), 32'd0);
        check("w1_cpu_lat",  32'(cpu_cyc - we_cyc), 32'd1);
        check("w1_done_lat", 32'(done_cyc - we_cyc), 32'd1);

        // Three words, then a trailing byte that must be ignored.
        reset_dut();
        send_byte(8'h03, 1'b1); send_byte(8'h00, 1'b1);
        send_word(32'h11223344);
        check("w3_mid_cpu", 32'(cpu_reset_n), 32'd0);
        send_word(32'hDEADBEEF);
        send_word(32'h00000093);
        send_byte(8'h55, 1'b1);
        wait_cycles(10);
        check("w3_count", 32'(wr_n), 32'd3);
        check("w3_a0", 32'(wr_addr[0]), 32'd0);
        check("w3_d0", wr_data[0], 32'h11223344);
        check("w3_a1", 32'(wr_addr[1]), 32'd1);
        check("w3_d1", wr_data[1], 32'hDEADBEEF);
        check("w3_a2", 32'(wr_addr[2]), 32'd2);
        check("w3_d2", wr_data[2], 32'h00000093);
        check("w3_done", 32'(load_done), 32'd1);
        check("w3_final_addr", 32'(imem_waddr), 32'd2);

        // Zero-length image.
        reset_dut();
        send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
        wait_cycles(5);
        check("z_done", 32'(load_done), 32'd1);
        check("z_cpu",  32'(cpu_reset_n), 32'd1);
        send_byte(8'hFF, 1'b1);
        wait_cycles(10);
        check("z_writes", 32'(wr_n), 32'd0);
        check("z_err",    32'(load_error), 32'd0);

        // Oversize count on the 4-word instance.
        reset_dut();
        send_byte(8'h05, 1'b1); send_byte(8'h00, 1'b1);
        wait_cycles(10);
        check("ov_err",  32'(s_error), 32'd1);
        check("ov_cpu",  32'(s_cpu_reset_n), 32'd0);
        check("ov_done", 32'(s_done), 32'd0);
        check("ov_writes", 32'(s_wr_n), 32'd0);

        // Exactly full capacity on the 4-word instance.
        reset_dut();
        send_byte(8'h04, 1'b1); send_byte(8'h00, 1'b1);
        wait_cycles(5);
        check("cap_hdr_err", 32'(s_error), 32'd0);
        for (int i = 0; i < 4; i++) send_word(32'hC0DE0000 + 32'(i));
        wait_cycles(10);
        check("cap_writes", 32'(s_wr_n), 32'd4);
        check("cap_last_addr", 32'(s_last_addr), 32'd3);
        check("cap_last_data", s_last_data, 32'hC0DE0003);
        check("cap_done", 32'(s_done), 32'd1);
        check("cap_hold_addr", 32'(s_waddr), 32'd3);

        // Framing error on the third byte.
        reset_dut();
        send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h13, 1'b0);
        wait_cycles(30);
        check("fe_err",    32'(load_error), 32'd1);
        check("fe_writes", 32'(wr_n), 32'd0);
        check("fe_cpu",    32'(cpu_reset_n), 32'd0);
        check("fe_done",   32'(load_done), 32'd0);

        // Short glitch must not produce a byte or an error.
        reset_dut();
        uart_rx = 1'b0;
        wait_cycles(2);
        uart_rx = 1'b1;
        wait_cycles(40);
        check("gl_err", 32'(load_error), 32'd0);

        // Reset mid-load, then a clean re-send.
        send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h13, 1'b1); send_byte(8'h05, 1'b1);
        reset_n = 1'b0;
        tick();
        check_reset_outputs("mid");
        reset_n = 1'b1;
        wait_cycles(2);
        send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
        send_word(32'h00A00513);
        wait_cycles(10);
        check("rs_count", 32'(wr_n), 32'd1);
        check("rs_addr",  32'(wr_addr[0]), 32'd0);
        check("rs_data",  wr_data[0], 32'h00A00513);
        check("rs_cpu",   32'(cpu_reset_n), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
